// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage interlock for load and multi-cycle results (RAW, WAW, MC structural).
// Define HAZARD_STALL_CNT_EN to add a wrapping stall-cycle counter on stall_cnt_o; otherwise it reads 0.
module hazard_scoreboard #(
    parameter int MC_LAT = 4,
    parameter int LD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [4:0]  RSaddr_i,
    input  logic [4:0]  RTaddr_i,
    input  logic        use_rs_i,
    input  logic        use_rt_i,
    input  logic        RegWrite_i,
    input  logic [4:0]  Regdst_i,
    input  logic        is_load_i,
    input  logic        is_mc_i,
    output logic        stall_o,
    output logic        mc_busy_o,
    output logic [31:0] pending_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [2:0] MC_L = 3'(MC_LAT);
    localparam logic [2:0] LD_L = 3'(LD_LAT);

    // Entry 0 is held at zero so r0 reads as never pending.
    logic [2:0] cnt_q [32];
    logic [2:0] cnt_d [32];
    logic [2:0] mc_cnt_q;
    logic [2:0] mc_cnt_d;
    logic [2:0] lat;
    logic       raw;
    logic       waw;
    logic       str;
    logic       issue;

    always_comb begin
        lat = 3'd0;
        if (is_mc_i) begin
            lat = MC_L;
        end else if (is_load_i) begin
            lat = LD_L;
        end
    end

    assign raw = (use_rs_i && (cnt_q[RSaddr_i] != 3'd0)) ||
                 (use_rt_i && (cnt_q[RTaddr_i] != 3'd0));
    assign waw = RegWrite_i && (Regdst_i != 5'd0) && (cnt_q[Regdst_i] > lat);
    assign str = is_mc_i && (mc_cnt_q != 3'd0);

    assign stall_o   = id_valid_i && (raw || waw || str);
    assign issue     = id_valid_i && !stall_o;
    assign mc_busy_o = (mc_cnt_q != 3'd0);

    always_comb begin
        cnt_d[0] = 3'd0;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = (cnt_q[r] != 3'd0) ? (cnt_q[r] - 3'd1) : 3'd0;
            if (issue && RegWrite_i && (lat != 3'd0) && (Regdst_i == 5'(r))) begin
                cnt_d[r] = lat;
            end
        end
    end

    always_comb begin
        mc_cnt_d = (mc_cnt_q != 3'd0) ? (mc_cnt_q - 3'd1) : 3'd0;
        if (issue && is_mc_i) begin
            mc_cnt_d = MC_L;
        end
    end

    always_comb begin
        pending_o[0] = 1'b0;
        for (int r = 1; r < 32; r++) begin
            pending_o[r] = (cnt_q[r] != 3'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 3'd0;
            end
            mc_cnt_q <= 3'd0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            mc_cnt_q <= mc_cnt_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    assign stall_cnt_d = stall_o ? (stall_cnt_q + 32'd1) : stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline interlock controller sitting beside the forwarding unit in the ID stage. It tracks every in-flight destination register whose result is not yet forwardable: load results and results from a non-pipelined multi-cycle unit. It stalls the instruction in ID on RAW, WAW or multi-cycle-unit structural hazards. Single-cycle ALU results are not tracked; the forwarding unit covers those.

## Interface
Parameters:
- MC_LAT, 4, cycles from multi-cycle op issue until its result is forwardable (2..7)
- LD_LAT, 1, cycles from load issue until its result is forwardable (1..MC_LAT)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID holds a real instruction (not a bubble)
- RSaddr_i  in  5  rs of ID instruction
- RTaddr_i  in  5  rt of ID instruction
- use_rs_i  in  1  ID instruction reads rs
- use_rt_i  in  1  ID instruction reads rt
- RegWrite_i  in  1  ID instruction writes a register
- Regdst_i  in  5  destination of ID instruction
- is_load_i  in  1  ID instruction is a load
- is_mc_i  in  1  ID instruction uses the multi-cycle unit (wins if is_load_i also set)
- stall_o  out  1  hold PC and IF/ID; insert bubble into ID/EX
- mc_busy_o  out  1  multi-cycle unit occupied
- pending_o  out  32  bit r set when register r has a non-zero counter; bit 0 always 0
- stall_cnt_o  out  32  stall-cycle count (see Configuration)

## Operation
- Per-register 3-bit counter cnt[1..31]; cnt[0] does not exist (reads as 0). Also a 3-bit mc_cnt.
- Latency class of the ID instruction: L = MC_LAT if is_mc_i, else LD_LAT if is_load_i, else 0.
- stall_o = id_valid_i & (raw | waw | str):
  - raw: (use_rs_i & cnt[RSaddr_i]≠0) | (use_rt_i & cnt[RTaddr_i]≠0)
  - waw: RegWrite_i & Regdst_i≠0 & cnt[Regdst_i] > L
  - str: is_mc_i & mc_cnt≠0
- Accepted issue: id_valid_i & ~stall_o.
- Every cycle, every non-zero cnt and mc_cnt decrements by 1, saturating at 0. Decrement is independent of stall, because downstream stages keep advancing.
- On accepted issue with RegWrite_i & Regdst_i≠0 & L≠0: cnt[Regdst_i] ← L. The load overrides that register's decrement in the same cycle.
- On accepted issue with is_mc_i: mc_cnt ← MC_LAT.
- Accepted ALU writes (L=0) to a pending register cannot occur because waw stalls them. Writes to r0 are never tracked.
- mc_busy_o = (mc_cnt≠0); pending_o[r] = (cnt[r]≠0).

## Timing
- stall_o is combinational from current state and ID inputs, valid in the same cycle. No path from stall_o back to inputs.
- A load issued in cycle t with LD_LAT=1: cnt=1 in t+1, so a dependent instruction in ID at t+1 stalls one cycle and proceeds at t+2.
- An mc op issued at t blocks dependents through t+MC_LAT and releases them at t+MC_LAT+1.
- Reset (asynchronous assert, any cycle, including mid-hazard): all cnt=0, mc_cnt=0. Outputs: stall_o follows inputs (0 with no hazard), mc_busy_o=0, pending_o=0, stall_cnt_o=0. The first edge after deassertion updates normally.
- Simultaneous decrement-to-zero and read: a counter that is 1 at cycle t still stalls at t. Release happens the cycle it reads 0.
- id_valid_i=0: stall_o=0 and no issue, but counters still decrement.

## Configuration
- HAZARD_STALL_CNT_EN defined: 32-bit counter, reset 0, increments on every cycle with stall_o=1, wraps from 0xFFFFFFFF to 0. It is driven on stall_cnt_o.
- Not defined: no counter flops; stall_cnt_o tied to 0.

## Test plan
- Load r5 (LD_LAT=1) issued at t, then add using rs=r5 at t+1 -> stall_o=1 for exactly one cycle, issue at t+2, pending_o[5] set only at t+1.
- mc op writing r8 (MC_LAT=4) at t, dependent on rt=r8 held in ID -> stall_o=1 in t+1..t+4, 0 at t+5. A second mc op in ID at t+1 also stalls until t+5 with mc_busy_o=1 meanwhile.
- mc op to r9 at t, then load to r9 at t+1 -> waw stall until cnt[9] ≤ 1 (released at t+4). After issue, cnt[9]=1.
- Load to r0, then read r0 -> no stall, pending_o=0 throughout.
- Assert rst_i low mid-stall (cnt[3]=3) -> pending_o=0, mc_busy_o=0, and the stall drops immediately without waiting for a clock.
- With HAZARD_STALL_CNT_EN: the scenario-2 sequence leaves stall_cnt_o=4. Without the macro it reads 0.
